// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter: two-master arbiter and command sequencer for the single
// Hack data-memory port. Requester A is the CPU data side, requester B is a
// secondary master. At most one access is accepted per cycle; the accepted
// access becomes a registered memory command in the following cycle, and
// read data is steered back to its owner after RD_LATENCY cycles.
// Writes at or above the keyboard address are swallowed and flagged on err.
module hack_mem_arbiter #(
    parameter int          POLICY     = 1,         // 0 = fixed priority (A wins), 1 = round-robin
    parameter int          RD_LATENCY = 1,         // command cycle to mem_out sample edge, 1..4
    parameter logic [14:0] KBD_ADDR   = 15'd24576  // keyboard address
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [14:0] a_addr,
    input  logic [15:0] a_wdata,
    input  logic        a_lock,
    output logic        a_ack,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [14:0] b_addr,
    input  logic [15:0] b_wdata,
    input  logic        b_lock,
    output logic        b_ack,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,

    output logic [14:0] mem_address,
    output logic        mem_load,
    output logic [15:0] mem_in,
    input  logic [15:0] mem_out,
    output logic        err
);

    localparam int LAST = RD_LATENCY - 1;

    // Arbitration state: which requester was granted last (1 = B) and the lock owner.
    logic        last_b;
    logic        lock_vld;
    logic        lock_b;

    // Grant decision for the current cycle.
    logic        grant_a;
    logic        grant_b;
    logic        gnt_any;

    // Selected access of the granted requester.
    logic [14:0] gnt_addr;
    logic        gnt_we;
    logic [15:0] gnt_wdata;
    logic        gnt_blocked;
    logic        gnt_oor;

    // Read tag pipeline; index N is the tag for the command issued N cycles ago.
    logic [LAST:0] vld_p;
    logic [LAST:0] own_p;   // 1 = read belongs to B
    logic [LAST:0] oor_p;   // 1 = address above the keyboard, data forced to zero

    logic [15:0] ret_data;

    // Grant: lock owner first, then fixed priority or round-robin; nothing while in reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            if (lock_vld && !lock_b && a_req) begin
                grant_a = 1'b1;
            end else if (lock_vld && lock_b && b_req) begin
                grant_b = 1'b1;
            end else if (a_req && b_req) begin
                if (POLICY == 0) begin
                    grant_a = 1'b1;
                end else if (last_b) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (a_req) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ack   = grant_a;
    assign b_ack   = grant_b;
    assign gnt_any = grant_a | grant_b;

    // Route the winner's access onto the shared command path and classify it.
    always_comb begin
        gnt_addr    = grant_b ? b_addr  : a_addr;
        gnt_we      = grant_b ? b_we    : a_we;
        gnt_wdata   = grant_b ? b_wdata : a_wdata;
        gnt_blocked = gnt_we && (gnt_addr >= KBD_ADDR);
        gnt_oor     = gnt_addr > KBD_ADDR;
    end

    // Round-robin pointer and lock ownership; both move only on a grant, lock also ends on owner idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b   <= 1'b1;
            lock_vld <= 1'b0;
            lock_b   <= 1'b0;
        end else if (grant_a) begin
            last_b   <= 1'b0;
            lock_vld <= a_lock;
            lock_b   <= 1'b0;
        end else if (grant_b) begin
            last_b   <= 1'b1;
            lock_vld <= b_lock;
            lock_b   <= 1'b1;
        end else if (lock_vld && ((lock_b && !b_req) || (!lock_b && !a_req))) begin
            lock_vld <= 1'b0;
        end
    end

    // Command register: address/data hold between accesses, load and err are single-cycle strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_address <= '0;
            mem_in      <= '0;
            mem_load    <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_load <= gnt_any && gnt_we && !gnt_blocked;
            err      <= gnt_any && gnt_blocked;
            if (gnt_any) begin
                mem_address <= gnt_addr;
            end
            if (gnt_any && gnt_we) begin
                mem_in <= gnt_wdata;
            end
        end
    end

    // Read tag pipeline: valid bits are flushed by reset, owner/range bits only matter when valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= gnt_any && !gnt_we;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
        own_p[0] <= grant_b;
        oor_p[0] <= gnt_oor;
        for (int i = 1; i < RD_LATENCY; i++) begin
            own_p[i] <= own_p[i-1];
            oor_p[i] <= oor_p[i-1];
        end
    end

    assign ret_data = oor_p[LAST] ? 16'h0000 : mem_out;

    // Read return: sample mem_out for the oldest tag and pulse rvalid to its owner; rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= vld_p[LAST] && !own_p[LAST];
            b_rvalid <= vld_p[LAST] &&  own_p[LAST];
            if (vld_p[LAST] && !own_p[LAST]) begin
                a_rdata <= ret_data;
            end
            if (vld_p[LAST] && own_p[LAST]) begin
                b_rdata <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Bench for hack_mem_arbiter: a per-cycle vector table against a round-robin,
// latency-1 instance, plus hand sequences on a latency-3 instance for
// pipelined read return and reset during reads in flight.
module tb_hack_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [14:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;

    // Latency-1 instance outputs
    logic        a_ack, b_ack, a_rvalid, b_rvalid, mem_load, err;
    logic [15:0] a_rdata, b_rdata, mem_in, mem_out;
    logic [14:0] mem_address;

    // Latency-3 instance outputs
    logic        a_ack3, b_ack3, a_rvalid3, b_rvalid3, mem_load3, err3;
    logic [15:0] a_rdata3, b_rdata3, mem_in3, mem_out3;
    logic [14:0] mem_address3;

    int n_chk = 0;
    int n_err = 0;

    // Read-only memory contents seen by both instances
    function automatic logic [15:0] rom(input logic [14:0] addr);
        case (addr)
            15'd1:     rom = 16'h0101;
            15'd2:     rom = 16'h0202;
            15'd3:     rom = 16'h0303;
            15'd100:   rom = 16'h1234;
            15'd200:   rom = 16'hA5A5;
            15'd24576: rom = 16'hBEEF;
            15'd30000: rom = 16'h5555;
            default:   rom = 16'h0000;
        endcase
    endfunction

    assign mem_out = rom(mem_address);

    // Memory with two extra cycles of read delay for the latency-3 instance
    logic [15:0] d1, d2;
    always @(posedge clk) begin
        d1 <= rom(mem_address3);
        d2 <= d1;
    end
    assign mem_out3 = d2;

    hack_mem_arbiter #(.POLICY(1), .RD_LATENCY(1), .KBD_ADDR(15'd24576)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_load(mem_load), .mem_in(mem_in),
        .mem_out(mem_out), .err(err)
    );

    hack_mem_arbiter #(.POLICY(1), .RD_LATENCY(3), .KBD_ADDR(15'd24576)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_ack(a_ack3), .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_ack(b_ack3), .b_rvalid(b_rvalid3), .b_rdata(b_rdata3),
        .mem_address(mem_address3), .mem_load(mem_load3), .mem_in(mem_in3),
        .mem_out(mem_out3), .err(err3)
    );

    typedef struct {
        int ar, aw, aa, ad, al;
        int br, bw, ba, bd, bl;
        int eaa, eba, eaddr, eload, ein, eerr, earv, eard, ebrv, ebrd;
    } vec_t;

    localparam int NV = 33;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_lock = 1'b0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_lock = 1'b0;
    endtask

    task automatic rd_a(input logic [14:0] addr);
        a_req = 1'b1; a_we = 1'b0; a_addr = addr;
    endtask

    task automatic rd_b(input logic [14:0] addr);
        b_req = 1'b1; b_we = 1'b0; b_addr = addr;
    endtask

    task automatic chk_reset3(input string tag);
        chk({tag, " mem_address"}, 32'(mem_address3), 0);
        chk({tag, " mem_load"},    32'(mem_load3),    0);
        chk({tag, " mem_in"},      32'(mem_in3),      0);
        chk({tag, " err"},         32'(err3),         0);
        chk({tag, " a_rvalid"},    32'(a_rvalid3),    0);
        chk({tag, " a_rdata"},     32'(a_rdata3),     0);
        chk({tag, " b_rvalid"},    32'(b_rvalid3),    0);
        chk({tag, " b_rdata"},     32'(b_rdata3),     0);
    endtask

    initial begin
        //        A: req we addr  wdata lock | B: req we addr wdata lock | aack back addr load in err arv ard brv brd
        tbl[0]  = '{1,0,100,0,0,          0,0,0,0,0,            1,0,0,0,0,0,              0,0,0,0};
        tbl[1]  = '{0,0,0,0,0,            0,0,0,0,0,            0,0,100,0,0,0,            0,0,0,0};
        tbl[2]  = '{0,0,0,0,0,            0,0,0,0,0,            0,0,100,0,0,0,            1,'h1234,0,0};
        tbl[3]  = '{0,0,0,0,0,            0,0,0,0,0,            0,0,100,0,0,0,            0,'h1234,0,0};
        tbl[4]  = '{1,1,16384,'hFFFF,0,   1,1,16385,'h00FF,0,   0,1,100,0,0,0,            0,'h1234,0,0};
        tbl[5]  = '{1,1,16384,'hFFFF,0,   1,1,16385,'h00FF,0,   1,0,16385,1,'h00FF,0,     0,'h1234,0,0};
        tbl[6]  = '{1,1,16384,'hFFFF,0,   1,1,16385,'h00FF,0,   0,1,16384,1,'hFFFF,0,     0,'h1234,0,0};
        tbl[7]  = '{1,1,16384,'hFFFF,0,   1,1,16385,'h00FF,0,   1,0,16385,1,'h00FF,0,     0,'h1234,0,0};
        tbl[8]  = '{0,0,0,0,0,            0,0,0,0,0,            0,0,16384,1,'hFFFF,0,     0,'h1234,0,0};
        tbl[9]  = '{0,0,0,0,0,            0,0,0,0,0,            0,0,16384,0,'hFFFF,0,     0,'h1234,0,0};
        tbl[10] = '{1,1,24576,'h1111,0,   0,0,0,0,0,            1,0,16384,0,'hFFFF,0,     0,'h1234,0,0};
        tbl[11] = '{1,1,30000,'h2222,0,   0,0,0,0,0,            1,0,24576,0,'h1111,1,     0,'h1234,0,0};
        tbl[12] = '{1,0,30000,0,0,        0,0,0,0,0,            1,0,30000,0,'h2222,1,     0,'h1234,0,0};
        tbl[13] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,30000,0,'h2222,0,     0,'h1234,0,0};
        tbl[14] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,30000,0,'h2222,0,     1,0,0,0};
        tbl[15] = '{1,0,24576,0,0,        0,0,0,0,0,            1,0,30000,0,'h2222,0,     0,0,0,0};
        tbl[16] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,24576,0,'h2222,0,     0,0,0,0};
        tbl[17] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,24576,0,'h2222,0,     1,'hBEEF,0,0};
        tbl[18] = '{0,0,0,0,0,            1,0,200,0,0,          0,1,24576,0,'h2222,0,     0,'hBEEF,0,0};
        tbl[19] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,200,0,'h2222,0,       0,'hBEEF,0,0};
        tbl[20] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,200,0,'h2222,0,       0,'hBEEF,1,'hA5A5};
        tbl[21] = '{1,0,100,0,0,          1,0,200,0,0,          1,0,200,0,'h2222,0,       0,'hBEEF,0,'hA5A5};
        tbl[22] = '{0,0,0,0,0,            1,0,200,0,0,          0,1,100,0,'h2222,0,       0,'hBEEF,0,'hA5A5};
        tbl[23] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,200,0,'h2222,0,       1,'h1234,0,'hA5A5};
        tbl[24] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,200,0,'h2222,0,       0,'h1234,1,'hA5A5};
        tbl[25] = '{0,0,0,0,0,            1,1,5,'h0001,1,       0,1,200,0,'h2222,0,       0,'h1234,0,'hA5A5};
        tbl[26] = '{1,1,7,'h0007,0,       1,1,6,'h0002,1,       0,1,5,1,'h0001,0,         0,'h1234,0,'hA5A5};
        tbl[27] = '{1,1,7,'h0007,0,       1,1,8,'h0003,1,       0,1,6,1,'h0002,0,         0,'h1234,0,'hA5A5};
        tbl[28] = '{1,1,7,'h0007,0,       0,0,0,0,0,            1,0,8,1,'h0003,0,         0,'h1234,0,'hA5A5};
        tbl[29] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,7,1,'h0007,0,         0,'h1234,0,'hA5A5};
        tbl[30] = '{1,0,300,0,0,          1,0,200,0,0,          0,1,7,0,'h0007,0,         0,'h1234,0,'hA5A5};
        tbl[31] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,200,0,'h0007,0,       0,'h1234,0,'hA5A5};
        tbl[32] = '{0,0,0,0,0,            0,0,0,0,0,            0,0,200,0,'h0007,0,       0,'h1234,1,'hA5A5};

        // Reset: acks suppressed while rst_n is low, registers at reset values after one edge
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rd_a(15'd100);
        rd_b(15'd200);
        #1;
        chk("rst a_ack", 32'(a_ack), 0);
        chk("rst b_ack", 32'(b_ack), 0);
        @(negedge clk);
        #1;
        chk("rst a_ack3", 32'(a_ack3), 0);
        chk("rst b_ack3", 32'(b_ack3), 0);
        chk("rst mem_address", 32'(mem_address), 0);
        chk("rst mem_load",    32'(mem_load),    0);
        chk("rst mem_in",      32'(mem_in),      0);
        chk("rst err",         32'(err),         0);
        chk("rst a_rvalid",    32'(a_rvalid),    0);
        chk("rst a_rdata",     32'(a_rdata),     0);
        chk("rst b_rvalid",    32'(b_rvalid),    0);
        chk("rst b_rdata",     32'(b_rdata),     0);

        // Cycle-by-cycle vector table on the latency-1 instance
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n   = 1'b1;
            a_req   = tbl[i].ar[0];
            a_we    = tbl[i].aw[0];
            a_addr  = 15'(tbl[i].aa);
            a_wdata = 16'(tbl[i].ad);
            a_lock  = tbl[i].al[0];
            b_req   = tbl[i].br[0];
            b_we    = tbl[i].bw[0];
            b_addr  = 15'(tbl[i].ba);
            b_wdata = 16'(tbl[i].bd);
            b_lock  = tbl[i].bl[0];
            #1;
            chk($sformatf("c%0d a_ack", i),       32'(a_ack),       tbl[i].eaa);
            chk($sformatf("c%0d b_ack", i),       32'(b_ack),       tbl[i].eba);
            chk($sformatf("c%0d mem_address", i), 32'(mem_address), tbl[i].eaddr);
            chk($sformatf("c%0d mem_load", i),    32'(mem_load),    tbl[i].eload);
            chk($sformatf("c%0d mem_in", i),      32'(mem_in),      tbl[i].ein);
            chk($sformatf("c%0d err", i),         32'(err),         tbl[i].eerr);
            chk($sformatf("c%0d a_rvalid", i),    32'(a_rvalid),    tbl[i].earv);
            chk($sformatf("c%0d a_rdata", i),     32'(a_rdata),     tbl[i].eard);
            chk($sformatf("c%0d b_rvalid", i),    32'(b_rvalid),    tbl[i].ebrv);
            chk($sformatf("c%0d b_rdata", i),     32'(b_rdata),     tbl[i].ebrd);
        end

        // Latency 3: reads A,B,A to 1,2,3 issued back to back, returned on consecutive cycles
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_a(15'd1);
        #1;
        chk("l3 g0 a_ack", 32'(a_ack3), 1);
        @(negedge clk);
        idle();
        rd_b(15'd2);
        #1;
        chk("l3 g1 b_ack", 32'(b_ack3), 1);
        chk("l3 g1 a_ack", 32'(a_ack3), 0);
        chk("l3 g1 mem_address", 32'(mem_address3), 1);
        @(negedge clk);
        idle();
        rd_a(15'd3);
        #1;
        chk("l3 g2 a_ack", 32'(a_ack3), 1);
        chk("l3 g2 mem_address", 32'(mem_address3), 2);
        @(negedge clk);
        idle();
        #1;
        chk("l3 g3 mem_address", 32'(mem_address3), 3);
        chk("l3 g3 a_rvalid", 32'(a_rvalid3), 0);
        chk("l3 g3 b_rvalid", 32'(b_rvalid3), 0);
        @(negedge clk);
        #1;
        chk("l3 g4 a_rvalid", 32'(a_rvalid3), 1);
        chk("l3 g4 a_rdata",  32'(a_rdata3),  'h0101);
        chk("l3 g4 b_rvalid", 32'(b_rvalid3), 0);
        @(negedge clk);
        #1;
        chk("l3 g5 a_rvalid", 32'(a_rvalid3), 0);
        chk("l3 g5 b_rvalid", 32'(b_rvalid3), 1);
        chk("l3 g5 b_rdata",  32'(b_rdata3),  'h0202);
        @(negedge clk);
        #1;
        chk("l3 g6 a_rvalid", 32'(a_rvalid3), 1);
        chk("l3 g6 a_rdata",  32'(a_rdata3),  'h0303);
        chk("l3 g6 b_rvalid", 32'(b_rvalid3), 0);
        @(negedge clk);
        #1;
        chk("l3 g7 a_rvalid", 32'(a_rvalid3), 0);
        chk("l3 g7 b_rvalid", 32'(b_rvalid3), 0);

        // Reset for one cycle with two reads in flight: they must never return
        @(negedge clk);
        rd_a(15'd1);
        #1;
        chk("flush h0 a_ack", 32'(a_ack3), 1);
        @(negedge clk);
        idle();
        rd_b(15'd2);
        #1;
        chk("flush h1 b_ack", 32'(b_ack3), 1);
        @(negedge clk);
        idle();
        rd_a(15'd1);
        rst_n = 1'b0;
        #1;
        chk("flush h2 a_ack3", 32'(a_ack3), 0);
        chk("flush h2 a_ack",  32'(a_ack),  0);
        chk("flush h2 b_ack3", 32'(b_ack3), 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        chk_reset3("flush h3");
        for (int k = 4; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("flush h%0d a_rvalid", k), 32'(a_rvalid3), 0);
            chk($sformatf("flush h%0d b_rvalid", k), 32'(b_rvalid3), 0);
        end
        @(negedge clk);
        rd_a(15'd3);
        #1;
        chk("flush h8 a_ack", 32'(a_ack3), 1);
        @(negedge clk);
        idle();
        for (int k = 9; k < 12; k++) begin
            #1;
            chk($sformatf("flush h%0d a_rvalid", k), 32'(a_rvalid3), 0);
            @(negedge clk);
        end
        #1;
        chk("flush h12 a_rvalid", 32'(a_rvalid3), 1);
        chk("flush h12 a_rdata",  32'(a_rdata3),  'h0303);
        chk("flush h12 b_rvalid", 32'(b_rvalid3), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hack_mem_arbiter.md
Name: hack_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single Hack data-memory port (RAM 0–16383, screen 16384–24575, keyboard 24576) exposed by the peripherals block.
- Port A is the CPU data side. Port B is a secondary master, such as a screen-fill or debug engine.
- Grants at most one access per cycle, drives the registered memory command, and routes read data back to the owning requester.
- Blocks illegal writes to the keyboard and unmapped space.

Parameters:
- POLICY, 1, arbitration mode: 0 = fixed priority (A wins), 1 = round-robin.
- RD_LATENCY, 1, cycles from the command being driven on mem_address to the edge at which mem_out is sampled (1 = sampled at the edge ending the command cycle); legal range 1–4.
- KBD_ADDR, 24576, keyboard address. Writes at or above it are blocked; reads above it return 0.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- a_req  in  1  A requests an access; a_addr, a_we and a_wdata are held stable while high and unacked.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  15  word address.
- a_wdata  in  16  write data.
- a_lock  in  1  when high at grant, A keeps priority on its following back-to-back requests.
- a_ack  out  1  combinational grant; the access is accepted at the rising edge ending this cycle.
- a_rvalid  out  1  one-cycle pulse: a_rdata holds the result of an accepted A read.
- a_rdata  out  16  read data.
- b_req, b_we, b_addr, b_wdata, b_lock, b_ack, b_rvalid, b_rdata: identical to the A ports, for requester B.
- mem_address  out  15  registered memory address.
- mem_load  out  1  registered write strobe, one cycle per write.
- mem_in  out  16  registered write data.
- mem_out  in  16  memory read data.
- err  out  1  one-cycle pulse: a blocked write was accepted.

Behaviour:
- Reset (rst_n low at a rising edge):
  - mem_address=0, mem_load=0, mem_in=0, a/b_rvalid=0, a/b_rdata=0, err=0.
  - Round-robin pointer favours A; locks are cleared; the read pipeline is flushed.
  - Reads in flight at reset never produce rvalid.
  - While rst_n is low, a_ack=b_ack=0.
- Grant in cycle T (combinational from the requests and state):
  - Only one ack per cycle.
  - If the lock owner is requesting, it wins.
  - Otherwise, POLICY=0: A beats B.
  - Otherwise, POLICY=1: the requester not granted most recently wins on conflict; a lone requester always wins.
  - The pointer updates only on a grant.
- Lock:
  - A requester granted with its lock input high becomes lock owner.
  - Ownership ends at the first cycle the owner has req low or is granted with lock low.
- Command issue:
  - An access accepted in T is driven during cycle C=T+1: mem_address=addr.
  - For a write: mem_in=wdata, mem_load=1 for C only.
  - Cycles with no grant: mem_load=0; mem_address and mem_in hold their last values.
  - Back-to-back accepts give one command per cycle, no bubble.
- Blocked write (addr >= KBD_ADDR):
  - Still acked and consumes cycle C.
  - In C: mem_load=0, mem_address=addr, err=1.
- Read return:
  - mem_out is sampled at the edge ending cycle C+RD_LATENCY-1.
  - The owner's rvalid=1 and rdata are driven in cycle C+RD_LATENCY.
  - An owner/valid/out-of-range tag pipeline of depth RD_LATENCY allows one read per cycle in flight.
  - Reads with addr > KBD_ADDR return rdata=0. A read of KBD_ADDR returns mem_out.
  - rdata holds its value between pulses.
  - Writes generate no rvalid.
- A request dropped before ack is legal and has no effect.
- Width rules: no address arithmetic; comparisons are unsigned 15-bit.

Test Plan:
- Reset, then A read of addr 100 (RAM holds 0x1234), RD_LATENCY=1. Required: a_ack in T, mem_address=100 in T+1, a_rvalid=1 and a_rdata=0x1234 in T+2, mem_load=0 throughout.
- POLICY=1, A and B both writing continuously (A: 16384 ← 0xFFFF, B: 16385 ← 0x00FF). Required: acks alternate A,B,A,B; mem_load=1 every cycle from T+1; no lost or duplicated writes.
- POLICY=1, B holds b_lock=1 for 3 back-to-back writes while A requests throughout. Required: B acked for 3 cycles, then A acked on the cycle after B drops req.
- A write to 24576 and then to 30000. Required: both acked, mem_load stays 0, err pulses in each C cycle. A read of 30000 gives a_rvalid with a_rdata=0.
- RD_LATENCY=3, reads issued A,B,A to addrs 1,2,3. Required: rvalid pulses on consecutive cycles, each routed to the correct owner with the matching data.
- rst_n low for one cycle while two reads are in flight. Required: no rvalid afterwards, all outputs at reset values, the next A read completes normally.
